// File: rtl/window_gen.sv
// window_gen: 3x3 sliding-window generator over a raster pixel stream.
// Optional WINDOW_GEN_SOF_EN adds sof_in to resynchronise the counters.
module window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        pixel_valid,
  input  logic [DATA_WIDTH-1:0]                       pixel_in,
`ifdef WINDOW_GEN_SOF_EN
  input  logic                                        sof_in,
`endif
  output logic                                        window_valid,
  output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out,
  output logic                                        frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int NW = K * K;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  // position of the next pixel to be accepted
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // position actually used for the pixel on the bus this cycle
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;

  logic          sof;
  logic          accept;
  logic          col_end;
  logic          frame_end;
  logic          win_hit;

  // two previous rows, indexed by column
  pix_t          lb_top [IMG_WIDTH];
  pix_t          lb_mid [IMG_WIDTH];

  // incoming column: top (row-2), middle (row-1), current pixel
  pix_t          new_col [K];

  // shifting 3x3 register window and its next value
  pix_t          win_q [NW];
  pix_t          win_d [NW];

  logic [DATA_WIDTH*NW-1:0] win_packed;

`ifdef WINDOW_GEN_SOF_EN
  assign sof = sof_in;
`else
  assign sof = 1'b0;
`endif

  assign accept = pixel_valid;

  // a start-of-frame pixel is forced to (row 0, col 0)
  always_comb begin
    col_cur   = col;
    row_cur   = row;
    if (sof) begin
      col_cur = '0;
      row_cur = '0;
    end
    col_end   = (col_cur == COL_LAST);
    frame_end = col_end && (row_cur == ROW_LAST);
    win_hit   = (row_cur >= ROW_MIN) && (col_cur >= COL_MIN);
  end

  // raster position counters, advanced only by accepted pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (frame_end) begin
        col <= '0;
        row <= '0;
      end else if (col_end) begin
        col <= '0;
        row <= row_cur + RW'(1);
      end else begin
        col <= col_cur + CW'(1);
        row <= row_cur;
      end
    end
  end

  // column fetched from the line buffers at the current position
  always_comb begin
    new_col[0] = lb_top[col_cur];
    new_col[1] = lb_mid[col_cur];
    new_col[2] = pixel_in;
  end

  // line buffers push the current column down by one row
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_cur] <= lb_mid[col_cur];
      lb_mid[col_cur] <= pixel_in;
    end
  end

  // next window: every row shifts left, new column enters on the right
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      win_d[i] = '0;
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r*K+c] = win_q[r*K+c+1];
      end
      win_d[r*K+K-1] = new_col[r];
    end
  end

  // pack element i = 3*r + c into its output slice
  always_comb begin
    win_packed = '0;
    for (int i = 0; i < NW; i++) begin
      win_packed[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = win_d[i];
    end
  end

  // register window shifts once per accepted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NW; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // publish complete windows only; output holds between windows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window_out   <= '0;
    end else begin
      window_valid <= accept && win_hit;
      frame_done   <= accept && frame_end;
      if (accept && win_hit) begin
        window_out <= win_packed;
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed checks for window_gen on a 4x4 image.
// Covers back-to-back, gapped, chained frames, mid-frame reset, sof.
module tb_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = DW * 9;

  typedef logic [WB-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pixel_valid;
  logic [DW-1:0] pixel_in;
  logic          window_valid;
  win_t          window_out;
  logic          frame_done;
`ifdef WINDOW_GEN_SOF_EN
  logic          sof_in;
`endif

  window_gen #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (3),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
`ifdef WINDOW_GEN_SOF_EN
    .sof_in       (sof_in),
`endif
    .window_valid (window_valid),
    .window_out   (window_out),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   m_row    = 0;
  int   m_col    = 0;
  int   vcnt     = 0;
  int   fdcnt    = 0;
  int   hits     = 0;
  logic [DW-1:0] img [H][W];
  win_t first_win;
  win_t last_win;
  win_t held;

  localparam win_t WIN_FIRST  = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6,
                                 8'd5, 8'd3, 8'd2, 8'd1};
  localparam win_t WIN_LAST   = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11,
                                 8'd10, 8'd8, 8'd7, 8'd6};
  localparam win_t WIN_FIRST2 = {8'd111, 8'd110, 8'd109, 8'd107,
                                 8'd106, 8'd105, 8'd103, 8'd102,
                                 8'd101};

  task automatic chk(input string tag, input win_t obs, input win_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic win_t exp_win();
    win_t w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(3*r+c)*DW +: DW] = img[m_row-2+r][m_col-2+c];
      end
    end
    return w;
  endfunction

  task automatic send(input logic [DW-1:0] v, input logic sof);
    bit   hit;
    bit   last;
    win_t ew;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = v;
    hit  = (m_row >= 2) && (m_col >= 2);
    last = (m_row == H - 1) && (m_col == W - 1);
    ew   = hit ? exp_win() : held;
    pixel_valid = 1'b1;
    pixel_in    = v;
`ifdef WINDOW_GEN_SOF_EN
    sof_in      = sof;
`endif
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    sof_in      = 1'b0;
`endif
    if (window_valid) vcnt++;
    if (frame_done) fdcnt++;
    chk("window_valid", win_t'(window_valid), win_t'(hit));
    chk("frame_done", win_t'(frame_done), win_t'(last));
    chk(hit ? "window_out" : "window_hold", window_out, ew);
    if (hit) begin
      hits++;
      if (hits == 1) first_win = window_out;
      last_win = window_out;
      held     = ew;
    end
    if (last) begin
      m_row = 0;
      m_col = 0;
    end else if (m_col == W - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (window_valid) vcnt++;
      if (frame_done) fdcnt++;
      chk("idle_hold", window_out, held);
    end
  endtask

  task automatic frame_start();
    vcnt  = 0;
    fdcnt = 0;
    hits  = 0;
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int p = 0; p < W * H; p++) begin
      send(DW'(base + 1 + p), 1'b0);
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        idle($urandom_range(1, 3));
      end
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_window_valid", win_t'(window_valid), '0);
    chk("rst_frame_done", win_t'(frame_done), '0);
    chk("rst_window_out", window_out, '0);
    rst_n = 1'b1;
    m_row = 0;
    m_col = 0;
    held  = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
`ifdef WINDOW_GEN_SOF_EN
    sof_in      = 1'b0;
`endif
    held        = '0;
    @(posedge clk);
    do_reset();

    // back-to-back frame 1..16
    frame_start();
    frame(0, 1'b0);
    chk("bb_first", first_win, WIN_FIRST);
    chk("bb_last", last_win, WIN_LAST);
    chk("bb_count", win_t'(vcnt), win_t'(4));
    chk("bb_done", win_t'(fdcnt), win_t'(1));
    idle(2);

    // same frame with random gaps
    frame_start();
    frame(0, 1'b1);
    chk("gap_first", first_win, WIN_FIRST);
    chk("gap_last", last_win, WIN_LAST);
    chk("gap_count", win_t'(vcnt), win_t'(4));
    chk("gap_done", win_t'(fdcnt), win_t'(1));

    // two frames without a bubble
    frame_start();
    frame(0, 1'b0);
    chk("chain1_count", win_t'(vcnt), win_t'(4));
    frame_start();
    frame(100, 1'b0);
    chk("chain2_first", first_win, WIN_FIRST2);
    chk("chain2_count", win_t'(vcnt), win_t'(4));
    chk("chain2_done", win_t'(fdcnt), win_t'(1));

    // reset after pixel 7, then a full frame
    frame_start();
    for (int p = 1; p <= 7; p++) send(DW'(p), 1'b0);
    do_reset();
    frame_start();
    frame(0, 1'b0);
    chk("rst_first", first_win, WIN_FIRST);
    chk("rst_last", last_win, WIN_LAST);
    chk("rst_count", win_t'(vcnt), win_t'(4));
    chk("rst_done", win_t'(fdcnt), win_t'(1));

`ifdef WINDOW_GEN_SOF_EN
    // aborted partial frame resynchronised by sof_in
    frame_start();
    for (int p = 1; p <= 9; p++) send(DW'(p), 1'b0);
    chk("sof_abort_done", win_t'(fdcnt), '0);
    frame_start();
    send(8'd1, 1'b1);
    for (int p = 2; p <= 16; p++) send(DW'(p), 1'b0);
    chk("sof_first", first_win, WIN_FIRST);
    chk("sof_last", last_win, WIN_LAST);
    chk("sof_count", win_t'(vcnt), win_t'(4));
    chk("sof_done", win_t'(fdcnt), win_t'(1));
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, window edge; only value 3 supported.
REQ-003 SHALL have parameter IMG_WIDTH, default 28, pixels per row; legal range >= 3.
REQ-004 SHALL have parameter IMG_HEIGHT, default 28, rows per frame; legal range >= 3.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port pixel_valid  input  1  pixel_in accepted this cycle when high.
REQ-008 SHALL have port pixel_in  input  DATA_WIDTH  raster-order pixel, row-major, top-left first.
REQ-009 SHALL have port window_valid  output  1  one-cycle pulse per completed 3x3 window.
REQ-010 SHALL have port window_out  output  DATA_WIDTH*9  packed window, element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL track column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) of the next pixel; both advance only on accepted pixels.
REQ-013 SHALL wrap col to 0 and increment row at col==IMG_WIDTH-1; at last pixel (row==IMG_HEIGHT-1, col==IMG_WIDTH-1) SHALL wrap both to 0.
REQ-014 SHALL store the two previous rows in two line buffers of depth IMG_WIDTH plus a 3x3 register window shifting left per accepted pixel.
REQ-015 SHALL pack element i = 3*r + c, r=0 top row (row-2), r=2 current row; c=0 leftmost (col-2), c=2 current pixel.
REQ-016 SHALL assert window_valid for exactly one cycle, the cycle after a pixel is accepted at row>=2 and col>=2; no padding, (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-017 SHALL update window_out in the same cycle as window_valid and hold it until the next window; window_out SHALL never expose a window straddling a row boundary.
REQ-018 SHALL tolerate arbitrary gaps in pixel_valid with no change in window content or count; no backpressure exists, output consumer always accepts.
REQ-019 SHALL pulse frame_done the cycle after the last pixel accepted, coincident with the final window_valid.
REQ-020 SHALL start the next frame immediately after wrap, accepting a pixel in the cycle after the last pixel with no bubble; rows of the previous frame SHALL not contribute to valid windows of the new frame.

Reset
REQ-021 SHALL, when rst_n low at a rising edge, clear col, row, window_valid, frame_done and window_out to 0.
REQ-022 SHALL not require line-buffer contents to be cleared; gating by counters makes them don't-care.
REQ-023 SHALL, on reset mid-frame, treat the first pixel accepted after release as (row 0, col 0); no window from the aborted frame SHALL appear.

Configuration
REQ-024 SHALL, with macro WINDOW_GEN_SOF_EN defined, add port sof_in  input  1; a pixel accepted with sof_in high SHALL be taken as (row 0, col 0), aborting any partial frame without frame_done.
REQ-025 SHALL, without WINDOW_GEN_SOF_EN, have no sof_in port; counters resynchronise only by rst_n or frame wrap.

Verification
REQ-026 SHALL cover IMG_WIDTH=IMG_HEIGHT=4, pixels 1..16 back-to-back -> 4 windows; first {1,2,3,5,6,7,9,10,11} one cycle after pixel 11, last {6,7,8,10,11,12,14,15,16} with frame_done.
REQ-027 SHALL cover same frame with pixel_valid random 50% duty -> identical 4 windows in order, window_valid count 4, frame_done once.
REQ-028 SHALL cover two frames back-to-back (1..16 then 101..116) -> second frame first window {101,102,103,105,106,107,109,110,111}, no mixed-frame windows.
REQ-029 SHALL cover rst_n low for one cycle after pixel 7, then pixels 1..16 -> exactly 4 windows matching REQ-026, all outputs 0 during reset.
REQ-030 SHALL cover with WINDOW_GEN_SOF_EN: pixels 1..9, then sof_in with pixels 1..16 -> no frame_done for the aborted frame, 4 windows matching REQ-026.
